fp_div_seq: RTL
===============

Name: fp_div_seq

Overview:
- Sequential signed fixed-point divider for the fixed-point arithmetic library; the division counterpart of the fixed-point multiplier.
- Accepts two two's-complement Q-format operands on a start/done handshake and produces a rounded-toward-zero quotient one bit per cycle using restoring division on magnitudes.
- Saturates out-of-range results and flags overflow, underflow and divide-by-zero.

Parameters:
- W_in, 16, word length of inputs a and b.
- W_in_F, 14, fractional bits of a and b.
- W_out, 16, word length of QUOTIENT.
- W_out_F, 14, fractional bits of QUOTIENT.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled on the rising edge.
- a  input  W_in  signed dividend.
- b  input  W_in  signed divisor.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; result valid.
- QUOTIENT  output  W_out  signed result, held until the next done.
- OVERFLOW  output  1  result exceeded the maximum positive value; saturated.
- UNDERFLOW  output  1  result below the minimum negative value; saturated.
- DIV_ZERO  output  1  b was zero.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset:
  - On rst assertion, immediately: state IDLE; busy, done, OVERFLOW, UNDERFLOW and DIV_ZERO = 0; QUOTIENT = 0.
  - rst asserted mid-operation aborts the operation; no done is issued.
- Arithmetic:
  - Real quotient is A/B.
  - Target integer is trunc(A * 2^W_out_F / B), truncated toward zero.
  - Dividend magnitude = |A| << W_out_F, width D = W_in + W_out_F (30 at defaults).
  - Divisor magnitude = |B|, W_in bits unsigned; |-2^(W_in-1)| must be representable.
  - Result sign = sign(a) XOR sign(b); a zero magnitude gives QUOTIENT 0 regardless of sign.
- States: IDLE, CALC, DONE.
  - IDLE: when start = 1 at edge k, latch |a|, |b| and the signs, clear the iteration counter, go to CALC. Set busy = 1 from edge k.
  - CALC: one restoring step per cycle (shift the partial remainder, trial-subtract the divisor, set the quotient bit), for exactly D cycles. Counter runs 0..D-1.
  - On the final step, go to DONE.
  - DONE: outputs update at this edge. done = 1 and busy = 0 for exactly one cycle, then return to IDLE.
- Latency: start sampled at edge k means done is high during the cycle following edge k+D+1, i.e. D+1 cycles after acceptance.
- start while busy = 1 is ignored.
- start during the DONE cycle is accepted, giving back-to-back operation.
- Saturation: let QMAX = 2^(W_out-1)-1 and QMIN = -2^(W_out-1).
  - Positive magnitude > QMAX: QUOTIENT = QMAX, OVERFLOW = 1.
  - Negative magnitude > 2^(W_out-1): QUOTIENT = QMIN, UNDERFLOW = 1.
  - Negative magnitude exactly 2^(W_out-1): QUOTIENT = QMIN, no flag.
- Divide by zero (b = 0):
  - Full D+1-cycle latency is still taken.
  - DIV_ZERO = 1 and OVERFLOW = UNDERFLOW = 0.
  - QUOTIENT = QMAX if a >= 0, QMIN if a < 0.
- Flags and QUOTIENT are registered, change only at the DONE edge or on reset, and are held between operations.
- Operands a and b may change after acceptance without affecting the result.

Test Plan:
- a=0x2000 (0.5), b=0x4000 (1.0), start pulse -> done exactly 31 cycles later; QUOTIENT=0x2000; all flags 0; busy high for 30 cycles.
- a=0x4000, b=0x6000 (1/1.5) -> 0x2AAA. a=0xC000, b=0x6000 -> 0xD556 (truncation toward zero).
- a=0x4000, b=0x2000 (2.0) -> QUOTIENT=0x7FFF, OVERFLOW=1. a=0x8000, b=0x2000 (-4.0) -> QUOTIENT=0x8000, UNDERFLOW=1. a=0x8000, b=0x4000 (-2.0 exact) -> 0x8000, no flag.
- a=0x1000, b=0x0000 -> DIV_ZERO=1, QUOTIENT=0x7FFF. a=0xF000, b=0 -> QUOTIENT=0x8000, DIV_ZERO=1.
- start re-pulsed while busy with different operands -> ignored; first result returned. start held during the done cycle -> second operation completes 31 cycles later.
- rst asserted 10 cycles into an operation -> all outputs 0 immediately; no done pulse; the next start works normally.

Source files
------------

// File: rtl/fp_div_seq.sv
// Sequential signed fixed-point divider: restoring division on magnitudes, saturating result.
// Latency: start accepted at edge k, done high in the cycle after edge k+D+1 (D = W_in + W_out_F).
// Backpressure: start is ignored while the divider is working; one operation in flight at a time.
module fp_div_seq #(
    parameter int W_in    = 16,
    parameter int W_in_F  = 14,
    parameter int W_out   = 16,
    parameter int W_out_F = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W_in-1:0]      a,
    input  logic [W_in-1:0]      b,
    output logic                 busy,
    output logic                 done,
    output logic [W_out-1:0]     QUOTIENT,
    output logic                 OVERFLOW,
    output logic                 UNDERFLOW,
    output logic                 DIV_ZERO
);

    // a and b share one binary point, so their fractional bits cancel in A/B;
    // only the output fraction width sets how far the dividend is pre-shifted.
    localparam int SHIFT = W_out_F + (W_in_F - W_in_F);
    localparam int D     = W_in + SHIFT;
    localparam int CW    = $clog2(D);

    localparam logic [D-1:0]     LIM     = {{(D-W_out){1'b0}}, 1'b1, {(W_out-1){1'b0}}};
    localparam logic [D-1:0]     QMAX_D  = LIM - 1'b1;
    localparam logic [W_out-1:0] QMAX    = {1'b0, {(W_out-1){1'b1}}};
    localparam logic [W_out-1:0] QMIN    = {1'b1, {(W_out-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [D-1:0]    dvd;    // remaining dividend bits, consumed MSB first
    logic [W_in-1:0] dvs;    // divisor magnitude
    logic [W_in-1:0] rem;    // partial remainder, always < dvs so W_in bits suffice
    logic [D-1:0]    quo;    // quotient magnitude being built
    logic            neg;
    logic            a_neg;
    logic            dz;

    logic [W_in-1:0] a_mag;
    logic [W_in-1:0] b_mag;
    logic [W_in:0]   rem_sh;
    logic            ge;
    logic [W_out-1:0] sat_q;
    logic            sat_ovf;
    logic            sat_unf;

    // Operand magnitudes; -2^(W_in-1) wraps to the unsigned value 2^(W_in-1), which is correct.
    assign a_mag = a[W_in-1] ? (~a + 1'b1) : a;
    assign b_mag = b[W_in-1] ? (~b + 1'b1) : b;

    // One restoring step: shift in the next dividend bit and trial-compare against the divisor.
    always_comb begin
        rem_sh = {rem, dvd[D-1]};
        ge     = (rem_sh >= {1'b0, dvs});
    end

    // Apply sign and saturation to the finished magnitude; divide-by-zero overrides everything.
    always_comb begin
        sat_q   = '0;
        sat_ovf = 1'b0;
        sat_unf = 1'b0;
        if (dz) begin
            sat_q = a_neg ? QMIN : QMAX;
        end else if (!neg) begin
            if (quo > QMAX_D) begin
                sat_q   = QMAX;
                sat_ovf = 1'b1;
            end else begin
                sat_q = quo[W_out-1:0];
            end
        end else begin
            if (quo > LIM) begin
                sat_q   = QMIN;
                sat_unf = 1'b1;
            end else begin
                sat_q = ~quo[W_out-1:0] + 1'b1;
            end
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            quo       <= '0;
            neg       <= 1'b0;
            a_neg     <= 1'b0;
            dz        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            QUOTIENT  <= '0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
            DIV_ZERO  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd   <= {a_mag, {SHIFT{1'b0}}};
                        dvs   <= b_mag;
                        rem   <= '0;
                        quo   <= '0;
                        neg   <= a[W_in-1] ^ b[W_in-1];
                        a_neg <= a[W_in-1];
                        dz    <= (b == '0);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    dvd <= {dvd[D-2:0], 1'b0};
                    if (ge) begin
                        rem <= W_in'(rem_sh - {1'b0, dvs});
                        quo <= {quo[D-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[W_in-1:0];
                        quo <= {quo[D-2:0], 1'b0};
                    end
                    if (cnt == CW'(D-1)) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    QUOTIENT  <= sat_q;
                    OVERFLOW  <= sat_ovf;
                    UNDERFLOW <= sat_unf;
                    DIV_ZERO  <= dz;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
